// File: rtl/mc6502_regfile.sv
// mc6502 programmer-visible register file: A, X, Y, S plus registered N/Z
// result flags for loads and transfers. Writes land one cycle after the
// enable is sampled; the RSEL read port is purely combinational.
module mc6502_regfile #(
    parameter logic [7:0] SP_RESET  = 8'hFD,
    parameter logic [7:0] AXY_RESET = 8'h00
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RDY,
    input  logic [7:0] D,
    input  logic       WE_A,
    input  logic       WE_X,
    input  logic       WE_Y,
    input  logic       WE_S,
    input  logic       SP_INC,
    input  logic       SP_DEC,
    input  logic [1:0] RSEL,
    output logic [7:0] RD,
    output logic [7:0] A,
    output logic [7:0] X,
    output logic [7:0] Y,
    output logic [7:0] S,
    output logic       N_OUT,
    output logic       Z_OUT,
    output logic       NZ_UPD
);

    logic [7:0] a_q, a_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] s_q, s_d;
    logic       n_q, n_d;
    logic       z_q, z_d;
    logic       nz_upd_q, nz_upd_d;
    logic       axy_we;

    assign axy_we = WE_A | WE_X | WE_Y;

    // Next-state: RDY = 0 freezes everything and drops the NZ_UPD pulse.
    always_comb begin
        a_d      = a_q;
        x_d      = x_q;
        y_d      = y_q;
        s_d      = s_q;
        n_d      = n_q;
        z_d      = z_q;
        nz_upd_d = 1'b0;
        if (RDY) begin
            if (WE_A) a_d = D;
            if (WE_X) x_d = D;
            if (WE_Y) y_d = D;
            // Explicit load beats inc/dec; inc and dec together cancel out.
            if (WE_S) begin
                s_d = D;
            end else if (SP_INC && !SP_DEC) begin
                s_d = s_q + 8'd1;
            end else if (SP_DEC && !SP_INC) begin
                s_d = s_q - 8'd1;
            end
            // S-only writes (TXS) leave the flags alone.
            if (axy_we) begin
                n_d      = D[7];
                z_d      = (D == 8'h00);
                nz_upd_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q      <= AXY_RESET;
            x_q      <= AXY_RESET;
            y_q      <= AXY_RESET;
            s_q      <= SP_RESET;
            n_q      <= 1'b0;
            z_q      <= 1'b1;
            nz_upd_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            x_q      <= x_d;
            y_q      <= y_d;
            s_q      <= s_d;
            n_q      <= n_d;
            z_q      <= z_d;
            nz_upd_q <= nz_upd_d;
        end
    end

    // Combinational read port, no bypass of a same-cycle write.
    always_comb begin
        RD = a_q;
        unique case (RSEL)
            2'd0: RD = a_q;
            2'd1: RD = x_q;
            2'd2: RD = y_q;
            2'd3: RD = s_q;
            default: RD = a_q;
        endcase
    end

    assign A      = a_q;
    assign X      = x_q;
    assign Y      = y_q;
    assign S      = s_q;
    assign N_OUT  = n_q;
    assign Z_OUT  = z_q;
    assign NZ_UPD = nz_upd_q;

endmodule

// File: doc/mc6502_regfile.md
Name: mc6502_regfile

Overview:
- Programmer-visible register file of the mc6502 datapath: accumulator A, index X, index Y and stack pointer S.
- Sits directly downstream of the 8-bit source multiplexers. The selected mux output arrives on D and is written to the registers.
- Register contents are returned to the mux data inputs through the direct outputs and the RSEL read port.
- Also produces the registered N/Z result flags for loads and transfers.

Parameters:
- SP_RESET, 8'hFD, value loaded into S on reset.
- AXY_RESET, 8'h00, value loaded into A, X and Y on reset.

Ports:
- CLK  in  1  single system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RDY  in  1  1 = advance, 0 = freeze all state (6502 RDY stall).
- D  in  8  write data from the source mux.
- WE_A  in  1  write D to A.
- WE_X  in  1  write D to X.
- WE_Y  in  1  write D to Y.
- WE_S  in  1  write D to S.
- SP_INC  in  1  S <= S + 1 (pull).
- SP_DEC  in  1  S <= S - 1 (push).
- RSEL  in  2  read-port select: 0 = A, 1 = X, 2 = Y, 3 = S.
- RD  out  8  combinational read of the register selected by RSEL.
- A  out  8  accumulator.
- X  out  8  X index.
- Y  out  8  Y index.
- S  out  8  stack pointer (stack address is {8'h01, S}, formed outside this block).
- N_OUT  out  1  bit 7 of the last A/X/Y write value.
- Z_OUT  out  1  1 when the last A/X/Y write value was 8'h00.
- NZ_UPD  out  1  one-cycle pulse: N_OUT/Z_OUT updated on this edge.

Behaviour:
- Clocking: one clock, CLK. Reset is asynchronous and active-low on RST_N. While RST_N = 0, all state is held at reset values regardless of CLK.
- Reset values: A = X = Y = AXY_RESET; S = SP_RESET; N_OUT = 0; Z_OUT = 1; NZ_UPD = 0. Reset asserted mid-operation discards any in-flight write immediately.
- Write latency: a write is visible on A/X/Y/S and RD one cycle after the enable is sampled. There is no write-through bypass: RD in the write cycle shows the old value.
- Stall: when RDY = 0, no register, flag or NZ_UPD changes; NZ_UPD is forced to 0 for the stalled cycle. RD stays combinational throughout.
- Multiple write enables: any combination of WE_A/WE_X/WE_Y may assert together; each selected register loads the same D.
- Stack pointer priority per cycle (RDY = 1):
  - WE_S = 1: S <= D. SP_INC and SP_DEC are ignored.
  - Else SP_INC = 1 and SP_DEC = 0: S <= S + 1, mod 256 (8'hFF -> 8'h00).
  - Else SP_DEC = 1 and SP_INC = 0: S <= S - 1, mod 256 (8'h00 -> 8'hFF).
  - Else (both or neither asserted): S holds.
- Flag update:
  - On any edge with RDY = 1 and (WE_A | WE_X | WE_Y) = 1: N_OUT <= D[7]; Z_OUT <= (D == 8'h00); NZ_UPD <= 1.
  - Otherwise N_OUT and Z_OUT hold and NZ_UPD <= 0.
  - WE_S alone never touches the flags (TXS semantics). WE_S together with an A/X/Y write does update them.
- Read port: RSEL decodes fully, with no undefined codes. Output is purely combinational from current register state.
- Arithmetic: all registers are 8-bit unsigned with no carry out. S wrap-around is silent; no overflow indication.

Test Plan:
1. Reset, then release RST_N → A = X = Y = 00, S = FD, Z_OUT = 1, N_OUT = 0, NZ_UPD = 0. Assert RST_N = 0 asynchronously mid-cycle after loading A = 5A → A returns to 00 without waiting for a clock edge.
2. D = 80 with WE_A = 1 for one cycle → next cycle A = 80, N_OUT = 1, Z_OUT = 0, NZ_UPD = 1 for exactly one cycle. Then D = 00 with WE_X = 1 and WE_Y = 1 → X = Y = 00, Z_OUT = 1, N_OUT = 0, A still 80.
3. S = 00 with SP_DEC = 1 → S = FF. SP_INC = 1 for two cycles → 00 then 01. SP_INC = SP_DEC = 1 → S unchanged.
4. WE_S = 1, D = 42, SP_INC = 1 in the same cycle → S = 42, N_OUT/Z_OUT unchanged, NZ_UPD = 0.
5. RDY = 0 with WE_A = 1, D = 33, SP_DEC = 1 → A, S and flags unchanged, NZ_UPD = 0. Raise RDY with the same inputs → A = 33, S decremented by 1.
6. Load A = 11, X = 22, Y = 33, S = 44, then sweep RSEL 0..3 → RD = 11, 22, 33, 44 in the same cycle as each RSEL change. During a WE_A cycle with D = 99, RD (RSEL = 0) = 11 in that cycle and 99 the following cycle.
